// File: rtl/glitc_intercom_pkg.sv
// glitc_intercom_pkg: shared state encoding, counter widths and saturating increment for lane alignment.
package glitc_intercom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b1100;

    localparam int SLIP_W   = 4;
    localparam int MATCH_W  = 8;
    localparam int ERR_W    = 8;
    localparam int SETTLE_W = 4;
    localparam int LOSS_W   = 4;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/glitc_intercom_align_ctrl_if.sv
// glitc_intercom_align_ctrl_if: control/status bundle between a lane aligner and its ISERDES/resync neighbour.
interface glitc_intercom_align_ctrl_if;
    import glitc_intercom_pkg::*;

    logic                align_req_i;
    logic                train_i;
    logic [3:0]          oq_i;
    logic                bitslip_o;
    logic                busy_o;
    logic                locked_o;
    logic                fail_o;
    logic [SLIP_W-1:0]   slip_count_o;
    logic [ERR_W-1:0]    err_count_o;

    modport master (
        output align_req_i, train_i, oq_i,
        input  bitslip_o, busy_o, locked_o, fail_o, slip_count_o, err_count_o
    );

    modport slave (
        input  align_req_i, train_i, oq_i,
        output bitslip_o, busy_o, locked_o, fail_o, slip_count_o, err_count_o
    );

endinterface

// File: rtl/glitc_intercom_align_ctrl.sv
// glitc_intercom_align_ctrl: bitslip-based word alignment of one intercom lane against a training pattern.
// Outputs are decoded straight from registered state and counters, so nothing combinational reaches them.
import glitc_intercom_pkg::*;

module glitc_intercom_align_ctrl #(
    parameter logic [3:0]  TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned MAX_SLIPS     = 8,
    parameter int unsigned LOSS_ERRORS   = 4
) (
    input logic                        sysclk_i,
    input logic                        rst_i,
    glitc_intercom_align_ctrl_if.slave lane
);

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [MATCH_W-1:0]    match_q, match_d;
    logic [SLIP_W-1:0]     slip_q, slip_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [LOSS_W-1:0]     loss_q, loss_d;
    logic [7:0]            loss_next;
    logic                  hit;

    assign hit       = lane.oq_i == TRAIN_PATTERN;
    assign loss_next = sat_inc(8'(loss_q));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        slip_d   = slip_q;
        err_d    = err_q;
        loss_d   = loss_q;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (lane.align_req_i) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    match_d  = '0;
                    slip_d   = '0;
                    err_d    = '0;
                    loss_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                    match_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (hit) begin
                    if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_d = ST_LOCKED;
                        loss_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    state_d = (slip_q < SLIP_W'(MAX_SLIPS)) ? ST_SLIP : ST_FAIL;
                end
            end
            ST_SLIP: begin
                slip_d   = slip_q + 1'b1;
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_LOCKED: begin
                // A restart request outranks a loss-of-lock on the same cycle and clears err_count.
                if (lane.align_req_i) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    match_d  = '0;
                    slip_d   = '0;
                    err_d    = '0;
                    loss_d   = '0;
                end else if (lane.train_i && !hit) begin
                    err_d = sat_inc(err_q);
                    if (loss_next == 8'(LOSS_ERRORS)) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                        match_d  = '0;
                        slip_d   = '0;
                        loss_d   = '0;
                    end else begin
                        loss_d = loss_next[LOSS_W-1:0];
                    end
                end else begin
                    loss_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            match_q  <= '0;
            slip_q   <= '0;
            err_q    <= '0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            slip_q   <= slip_d;
            err_q    <= err_d;
            loss_q   <= loss_d;
        end
    end

    assign lane.bitslip_o    = state_q == ST_SLIP;
    assign lane.busy_o       = (state_q == ST_SETTLE) || (state_q == ST_CHECK) || (state_q == ST_SLIP);
    assign lane.locked_o     = state_q == ST_LOCKED;
    assign lane.fail_o       = state_q == ST_FAIL;
    assign lane.slip_count_o = slip_q;
    assign lane.err_count_o  = err_q;

endmodule

// File: tb/tb_glitc_intercom_align_ctrl.sv
// tb_glitc_intercom_align_ctrl: scoreboard bench; expectations queued with each stimulus, popped as results appear.
module tb_glitc_intercom_align_ctrl;

    localparam logic [3:0] PAT    = 4'b1100;
    localparam int         SETTLE = 4;
    localparam int         LOCKN  = 16;
    localparam int         MAXS   = 8;
    localparam int         LOSS   = 4;

    logic sysclk;
    logic rst;

    glitc_intercom_align_ctrl_if bus();

    glitc_intercom_align_ctrl #(
        .TRAIN_PATTERN(PAT),
        .SETTLE_CYCLES(SETTLE),
        .LOCK_COUNT(LOCKN),
        .MAX_SLIPS(MAXS),
        .LOSS_ERRORS(LOSS)
    ) dut (
        .sysclk_i(sysclk),
        .rst_i(rst),
        .lane(bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        string tag;
        int    exp;
    } sb_t;

    sb_t sbq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc, slips, last_slip, gap_bad, offset, busy_cnt, at;
    bit  rot_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int exp);
        sbq.push_back('{tag, exp});
    endtask

    task automatic observe(input int got);
        sb_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", sbq.size(), 1);
        end else begin
            e = sbq.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic int outs();
        return int'({bus.bitslip_o, bus.busy_o, bus.locked_o, bus.fail_o, bus.slip_count_o, bus.err_count_o});
    endfunction

    // The lane model rotates the received word by one position per observed bitslip pulse.
    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
        if (bus.busy_o) busy_cnt++;
        if (bus.bitslip_o) begin
            if (last_slip >= 0 && cyc - last_slip < SETTLE + 2) gap_bad++;
            last_slip = cyc;
            slips++;
            offset = (offset + 3) % 4;
            if (rot_en) bus.oq_i = rotl(PAT, offset);
        end
    endtask

    task automatic start();
        bus.align_req_i = 1'b1;
        cyc = 0;
        slips = 0;
        last_slip = -1;
        gap_bad = 0;
        busy_cnt = 0;
        tick();
        bus.align_req_i = 1'b0;
    endtask

    task automatic wait_lock(output int lock_at);
        for (int i = 0; i < 400 && !bus.locked_o; i++) tick();
        lock_at = bus.locked_o ? cyc : -1;
    endtask

    task automatic wait_fail();
        for (int i = 0; i < 400 && !bus.fail_o; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.align_req_i = 1'b0;
        bus.train_i = 1'b0;
        bus.oq_i = PAT;
        rot_en = 1'b0;
        offset = 0;
        cyc = 0;
        slips = 0;
        last_slip = -1;
        gap_bad = 0;
        busy_cnt = 0;
        repeat (3) @(posedge sysclk);
        #1;
        rst = 1'b0;
        expect_val("reset_outs", 0);
        observe(outs());

        expect_val("rst_mid_busy", 1);
        expect_val("rst_mid_outs", 0);
        expect_val("rst_idle_outs", 0);
        expect_val("rst_relock_cycle", 21);
        start();
        while (cyc < 10) tick();
        observe(int'(bus.busy_o));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        observe(outs());
        repeat (5) tick();
        observe(outs());
        start();
        wait_lock(at);
        observe(at);

        expect_val("clean_lock_cycle", 21);
        expect_val("clean_busy_cycles", 20);
        expect_val("clean_slips", 0);
        expect_val("clean_slip_count", 0);
        expect_val("clean_busy_at_lock", 0);
        start();
        wait_lock(at);
        observe(at);
        observe(busy_cnt);
        observe(slips);
        observe(int'(bus.slip_count_o));
        observe(int'(bus.busy_o));

        expect_val("rot_lock_cycle", 33);
        expect_val("rot_slips", 2);
        expect_val("rot_gap_bad", 0);
        expect_val("rot_slip_count", 2);
        rot_en = 1'b1;
        offset = 2;
        bus.oq_i = rotl(PAT, 2);
        start();
        wait_lock(at);
        rot_en = 1'b0;
        observe(at);
        observe(slips);
        observe(gap_bad);
        observe(int'(bus.slip_count_o));

        expect_val("fail_slips", MAXS);
        expect_val("fail_flag", 1);
        expect_val("fail_busy", 0);
        expect_val("fail_slip_count", MAXS);
        expect_val("fail_gap_bad", 0);
        expect_val("fail_hold", 1);
        bus.oq_i = 4'b0000;
        start();
        wait_fail();
        observe(slips);
        observe(int'(bus.fail_o));
        observe(int'(bus.busy_o));
        observe(int'(bus.slip_count_o));
        observe(gap_bad);
        repeat (5) tick();
        observe(int'(bus.fail_o));

        expect_val("restart_slip_count", 0);
        expect_val("restart_fail", 0);
        expect_val("restart_busy", 1);
        expect_val("restart_lock_cycle", 21);
        bus.oq_i = PAT;
        start();
        observe(int'(bus.slip_count_o));
        observe(int'(bus.fail_o));
        observe(int'(bus.busy_o));
        wait_lock(at);
        observe(at);

        expect_val("loss_locked_after3", 1);
        expect_val("loss_locked_after_match3", 1);
        expect_val("loss_locked_after4", 0);
        expect_val("loss_err_count", 7);
        expect_val("loss_busy", 1);
        expect_val("loss_slip_count", 0);
        bus.train_i = 1'b1;
        bus.oq_i = 4'b0000;
        repeat (3) tick();
        observe(int'(bus.locked_o));
        bus.oq_i = PAT;
        tick();
        bus.oq_i = 4'b0000;
        repeat (3) tick();
        observe(int'(bus.locked_o));
        tick();
        observe(int'(bus.locked_o));
        observe(int'(bus.err_count_o));
        observe(int'(bus.busy_o));
        observe(int'(bus.slip_count_o));

        expect_val("relock_locked", 1);
        expect_val("relock_err_held", 7);
        expect_val("notrain_locked", 1);
        expect_val("notrain_err", 7);
        bus.oq_i = PAT;
        wait_lock(at);
        observe(int'(bus.locked_o));
        observe(int'(bus.err_count_o));
        bus.train_i = 1'b0;
        bus.oq_i = 4'b0000;
        repeat (4) tick();
        observe(int'(bus.locked_o));
        observe(int'(bus.err_count_o));

        expect_val("prio_err_before", 10);
        expect_val("prio_locked", 0);
        expect_val("prio_err_cleared", 0);
        expect_val("prio_busy", 1);
        bus.train_i = 1'b1;
        repeat (3) tick();
        observe(int'(bus.err_count_o));
        bus.align_req_i = 1'b1;
        tick();
        bus.align_req_i = 1'b0;
        observe(int'(bus.locked_o));
        observe(int'(bus.err_count_o));
        observe(int'(bus.busy_o));

        check("sb_leftover", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glitc_intercom_align_ctrl.md
Name: glitc_intercom_align_ctrl

Overview:
Sequences word alignment of one GLITC intercom receive lane. It sits beside the lane's ISERDES + sysclk resync block. It consumes the resynced 4-bit word, compares it against a known training pattern, and issues single-cycle bitslip pulses with a settle hold-off until it has seen LOCK_COUNT consecutive matches. It then reports lock, keeps an error count while the far side is still training, and re-aligns on loss of lock.

Parameters:
TRAIN_PATTERN, 4'b1100, expected 4-bit training word; all four rotations must be distinct.
SETTLE_CYCLES, 4, sysclk cycles ignored after each bitslip/start (1..15).
LOCK_COUNT, 16, consecutive matches required for lock (1..255).
MAX_SLIPS, 8, bitslips allowed before declaring failure (1..15).
LOSS_ERRORS, 4, consecutive mismatches in LOCKED (while train_i=1) that drop lock (1..15).

Ports:
sysclk_i  in  1  system clock; all logic on its rising edge
rst_i  in  1  synchronous active-high reset
align_req_i  in  1  start/restart alignment (level or pulse)
train_i  in  1  far side is transmitting TRAIN_PATTERN; enables loss monitoring in LOCKED
oq_i  in  4  resynced ISERDES word (from the lane's sysclk FD stage)
bitslip_o  out  1  one-cycle bitslip pulse to the ISERDES
busy_o  out  1  alignment in progress (SETTLE/CHECK/SLIP)
locked_o  out  1  lane aligned
fail_o  out  1  alignment exhausted MAX_SLIPS
slip_count_o  out  4  bitslips issued in the current attempt
err_count_o  out  8  mismatches seen in LOCKED with train_i=1; saturates at 255

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; every output 0; all counters 0. Reset wins over every other input.
- All outputs are registered and decoded from the state/counters. No combinational path from inputs to outputs.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE/LOCKED/FAIL + align_req_i=1 -> SETTLE.
  - Clears slip_count, match_cnt, settle counter, err_count and the consecutive-loss counter.
  - Clears locked_o and fail_o.
- align_req_i is ignored in SETTLE, CHECK and SLIP.
- SETTLE: busy_o=1. Stays exactly SETTLE_CYCLES cycles; oq_i is not examined. Then -> CHECK with match_cnt=0.
- CHECK: busy_o=1. Each cycle, oq_i is compared with TRAIN_PATTERN.
  - Match: match_cnt+1. On the LOCK_COUNT-th consecutive match -> LOCKED.
  - Mismatch, slip_count<MAX_SLIPS -> SLIP.
  - Mismatch, slip_count==MAX_SLIPS -> FAIL.
- SLIP: one cycle. bitslip_o=1 for exactly this cycle. slip_count+1. -> SETTLE.
  - bitslip_o is never high on two consecutive cycles.
  - Consecutive bitslip pulses are at least SETTLE_CYCLES+2 cycles apart.
- LOCKED: locked_o=1, busy_o=0.
  - With train_i=1 and oq_i!=TRAIN_PATTERN: err_count +1 (saturating) and loss counter +1.
  - Any match, or train_i=0: loss counter cleared.
  - Loss counter reaching LOSS_ERRORS -> SETTLE. locked_o drops, slip_count cleared, err_count is held (not cleared).
  - align_req_i has priority over loss detection on the same cycle.
- FAIL: fail_o=1, busy_o=0, slip_count_o holds MAX_SLIPS. Leaves only via align_req_i or rst_i.
- Latency with no slip needed, align_req_i sampled at edge 0:
  - SETTLE for cycles 1..SETTLE_CYCLES.
  - CHECK for the following LOCK_COUNT cycles.
  - locked_o high from cycle SETTLE_CYCLES+LOCK_COUNT+1 (defaults: cycle 21).
- Each slip adds 1+SETTLE_CYCLES cycles, plus the CHECK cycles spent before the mismatch.
- A mismatch in CHECK restarts the match count only through SLIP. There is no partial-credit retry at the same position.
- Clock relationship: bitslip_o is launched on sysclk. The integration guarantees sysclk is the ISERDES CLKDIV (or phase-locked to it), so one sysclk pulse equals one bitslip operation.

Decomposition:
- glitc_intercom_pkg holds:
  - state encoding enum (IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL);
  - default training pattern constant 4'b1100;
  - counter width constants (slip 4, match 8, err 8, settle 4).
- No sub-module. A small saturating-counter function in the package is shared by err_count and the loss counter.

Test Plan:
- Reset mid-CHECK (rst_i pulsed at cycle 10 after align_req_i) -> next cycle all outputs 0, state IDLE; a new align_req_i with oq_i=4'b1100 gives locked_o at cycle 21.
- oq_i=4'b1100 constant, align_req_i pulse -> no bitslip_o, slip_count_o=0, locked_o rises at cycle 21, busy_o high for cycles 1..20.
- Model rotates oq_i by one bit per bitslip_o, starting 2 rotations off -> exactly 2 bitslip pulses, each followed by ≥5 cycles without a pulse; locked_o set, slip_count_o=2.
- oq_i never matches (4'b0000), MAX_SLIPS=8 -> exactly 8 bitslip pulses, then fail_o=1, busy_o=0, slip_count_o=8; align_req_i restarts with slip_count_o=0.
- In LOCKED with train_i=1, inject 3 mismatches, one match, then 4 mismatches -> err_count_o=7; lock drops only after the 4th consecutive mismatch; the same 4 mismatches with train_i=0 leave locked_o=1, err_count_o unchanged.
- align_req_i asserted in LOCKED on the same cycle as the LOSS_ERRORS-th mismatch -> SETTLE entered, err_count_o cleared to 0, locked_o=0 the next cycle.
